// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N:1 valid/ready stream mux, fixed-select or round-robin, packet-locked grant
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, lock_ch, grant, rr_grant, idx;
  logic grant_valid, load, in_beat, sel_ok;
  always_comb begin
    rr_grant = '0;
    idx = '0;
    // walk downward so the channel closest after rr_ptr is written last and wins
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
      if (in_valid[idx]) rr_grant = idx;
    end
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb
    state_nxt = !in_beat ? state : in_last[grant] ? IDLE : LOCKED;
  always_comb begin
    sel_ok = int'(sel) < NUM_CH;
    grant = state == LOCKED ? lock_ch : mode ? rr_grant : sel;
    grant_valid = state == LOCKED ? in_valid[lock_ch] : mode ? |in_valid : sel_ok & in_valid[sel];
    load = !out_valid | out_ready;
    in_beat = rst_n & load & grant_valid;
    in_ready = in_beat ? {{(NUM_CH-1){1'b0}}, 1'b1} << grant : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
      lock_ch <= '0;
      rr_ptr <= SEL_W'(NUM_CH - 1);
    end else if (in_beat) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_last <= in_last[grant];
      out_ch <= grant;
      lock_ch <= grant;
      rr_ptr <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed vectors for stream_mux_arb; inputs change on negedge, checks 1ns later
module tb_stream_mux_arb;
  logic clk = 1'b0, rst_n, mode, out_ready, out_valid, out_last;
  logic [1:0] sel, out_ch;
  logic [3:0] in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic [7:0] out_data;
  int errors = 0, checks = 0;

  typedef struct {
    logic r, m;
    logic [1:0] s;
    logic [3:0] iv, il;
    logic [31:0] d;
    logic ordy;
    logic [3:0] eir;
    logic eov;
    logic [7:0] eod;
    logic eol;
    logic [1:0] eoc;
  } vec_t;
  vec_t tbl[14];

  stream_mux_arb #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string sig, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, sig, act, exp);
    end
  endtask

  // expected outputs describe the registered state before this cycle's rising edge
  task automatic cyc(input string tag, input logic r, input logic m, input logic [1:0] s,
                     input logic [3:0] iv, input logic [3:0] il, input logic [31:0] d, input logic ordy,
                     input logic [3:0] eir, input logic eov, input logic [7:0] eod, input logic eol,
                     input logic [1:0] eoc);
    @(negedge clk);
    rst_n = r; mode = m; sel = s; in_valid = iv; in_last = il; in_data = d; out_ready = ordy;
    #1;
    chk(tag, "in_ready", 32'(in_ready), 32'(eir));
    chk(tag, "out_valid", 32'(out_valid), 32'(eov));
    chk(tag, "out_data", 32'(out_data), 32'(eod));
    chk(tag, "out_last", 32'(out_last), 32'(eol));
    chk(tag, "out_ch", 32'(out_ch), 32'(eoc));
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 2'd2, 4'b0100, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd2},
      '{1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd2},
      '{1'b1, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h3322_1100, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h3322_1100, 1'b1, 4'b0010, 1'b1, 8'h00, 1'b1, 2'd0},
      '{1'b1, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h3322_1100, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd1},
      '{1'b1, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h3322_1100, 1'b1, 4'b1000, 1'b1, 8'h22, 1'b1, 2'd2},
      '{1'b1, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h3322_1100, 1'b1, 4'b0001, 1'b1, 8'h33, 1'b1, 2'd3},
      '{1'b1, 1'b1, 2'd0, 4'b1011, 4'b1001, 32'h3A00_100A, 1'b1, 4'b0010, 1'b1, 8'h00, 1'b1, 2'd0},
      '{1'b1, 1'b1, 2'd0, 4'b1011, 4'b1001, 32'h3A00_110A, 1'b1, 4'b0010, 1'b1, 8'h10, 1'b0, 2'd1},
      '{1'b1, 1'b1, 2'd0, 4'b1011, 4'b1011, 32'h3A00_120A, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1},
      '{1'b1, 1'b1, 2'd0, 4'b1001, 4'b1001, 32'h3A00_000A, 1'b1, 4'b1000, 1'b1, 8'h12, 1'b1, 2'd1},
      '{1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b1, 8'h3A, 1'b1, 2'd3},
      '{1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h3A, 1'b1, 2'd3}
    };
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    foreach (tbl[i])
      cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].iv, tbl[i].il, tbl[i].d,
          tbl[i].ordy, tbl[i].eir, tbl[i].eov, tbl[i].eod, tbl[i].eol, tbl[i].eoc);
    // backpressure in the middle of a ch0 packet while ch2 waits
    cyc("bp1", 1, 1, 0, 4'b0001, 4'b0000, 32'h0000_0050, 1, 4'b0001, 0, 8'h3A, 1, 2'd3);
    cyc("bp2", 1, 1, 0, 4'b0101, 4'b0000, 32'h0077_0051, 0, 4'b0000, 1, 8'h50, 0, 2'd0);
    cyc("bp3", 1, 1, 0, 4'b0101, 4'b0000, 32'h0077_0051, 0, 4'b0000, 1, 8'h50, 0, 2'd0);
    cyc("bp4", 1, 1, 0, 4'b0101, 4'b0000, 32'h0077_0051, 0, 4'b0000, 1, 8'h50, 0, 2'd0);
    cyc("bp5", 1, 1, 0, 4'b0101, 4'b0000, 32'h0077_0051, 1, 4'b0001, 1, 8'h50, 0, 2'd0);
    cyc("bp6", 1, 1, 0, 4'b0101, 4'b0000, 32'h0077_0052, 1, 4'b0001, 1, 8'h51, 0, 2'd0);
    cyc("bp7", 1, 1, 0, 4'b0101, 4'b0001, 32'h0077_0053, 1, 4'b0001, 1, 8'h52, 0, 2'd0);
    cyc("bp8", 1, 1, 0, 4'b0100, 4'b0100, 32'h0077_0000, 1, 4'b0100, 1, 8'h53, 1, 2'd0);
    cyc("bp9", 1, 1, 0, 4'b0000, 4'b0000, 32'h0,         1, 4'b0000, 1, 8'h77, 1, 2'd2);
    // fixed select changes 1->3 mid-packet, with an idle gap on the locked channel
    cyc("sw1", 1, 0, 1, 4'b1010, 4'b1000, 32'hD000_B000, 1, 4'b0010, 0, 8'h77, 1, 2'd2);
    cyc("sw2", 1, 0, 3, 4'b1010, 4'b1000, 32'hD000_B100, 1, 4'b0010, 1, 8'hB0, 0, 2'd1);
    cyc("sw3", 1, 0, 3, 4'b1000, 4'b1000, 32'hD000_0000, 1, 4'b0000, 1, 8'hB1, 0, 2'd1);
    cyc("sw4", 1, 0, 3, 4'b1010, 4'b1010, 32'hD000_B200, 1, 4'b0010, 0, 8'hB1, 0, 2'd1);
    cyc("sw5", 1, 0, 3, 4'b1000, 4'b1000, 32'hD000_0000, 1, 4'b1000, 1, 8'hB2, 1, 2'd1);
    cyc("sw6", 1, 0, 3, 4'b0000, 4'b0000, 32'h0,         1, 4'b0000, 1, 8'hD0, 1, 2'd3);
    // reset while locked on ch2 with a held beat
    cyc("rs1", 1, 1, 0, 4'b0100, 4'b0000, 32'h00C0_0000, 1, 4'b0100, 0, 8'hD0, 1, 2'd3);
    cyc("rs2", 0, 1, 0, 4'b0100, 4'b0000, 32'h00C0_0000, 1, 4'b0000, 1, 8'hC0, 0, 2'd2);
    cyc("rs3", 1, 1, 0, 4'b0101, 4'b0101, 32'h00C1_00E0, 1, 4'b0001, 0, 8'h00, 0, 2'd0);
    cyc("rs4", 1, 1, 0, 4'b0000, 4'b0000, 32'h0,         1, 4'b0000, 1, 8'hE0, 1, 2'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
